// File: rtl/det_arb.sv
// det_arb: two-requester round-robin arbiter that serialises the granted byte
// MSB-first into a shared external "11" sequence detector, drains it with
// FLUSH_BITS zero bits, counts detector hits and returns them as a response.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (shared with the detector)
//   req[1:0]   per-requester level request, held with its data until gnt
//   data0/1    requester bytes
//   gnt[1:0]   one-cycle acceptance pulse, issued in IDLE in the request cycle
//   det_in     serial bit to the detector (registered)
//   det_out    detector hit indication
//   rsp_valid  response available, held until rsp_ready
//   rsp_ready  response consumer ready
//   rsp_id     requester index of the response
//   rsp_hits   hit count for the byte (saturates at 7)
//   busy       high whenever the block is not in IDLE
module det_arb #(
    parameter int unsigned FLUSH_BITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] gnt,
    output logic       det_in,
    input  logic       det_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [2:0] rsp_hits,
    output logic       busy
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HIT_W  = 3;
    localparam int unsigned CNT_W  = (FLUSH_BITS > BYTE_W) ? $clog2(FLUSH_BITS) : $clog2(BYTE_W);

    localparam logic [CNT_W-1:0] SEND_LAST  = CNT_W'(BYTE_W - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_BITS - 1);
    localparam logic [HIT_W-1:0] HIT_MAX    = '1;

    // A single flush bit cannot both expose a trailing hit and return the detector to idle.
    generate
        if (FLUSH_BITS < 2) begin : g_bad_flush
            $error("det_arb: FLUSH_BITS must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BYTE_W-1:0]  r_shift;
    logic [BYTE_W-1:0]  w_shift_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [HIT_W-1:0]   r_hits;
    logic [HIT_W-1:0]   w_hits_nxt;
    logic               r_last;
    logic               w_last_nxt;
    logic               r_id;
    logic               w_id_nxt;
    logic               r_det_in;
    logic               r_rsp_valid;
    logic               r_busy;
    logic               w_grant_any;
    logic               w_pref;
    logic               w_grant_id;
    logic [1:0]         w_gnt;
    logic               w_count_hit;

    // Round-robin pick: the requester not granted last has priority.
    always_comb begin
        w_grant_any = |req;
        w_pref      = ~r_last;
        w_grant_id  = req[w_pref] ? w_pref : ~w_pref;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_any) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (r_cnt == SEND_LAST) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (r_cnt == FLUSH_LAST) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        w_gnt       = 2'b00;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_hits_nxt  = r_hits;
        w_last_nxt  = r_last;
        w_id_nxt    = r_id;
        w_count_hit = det_out && (r_hits != HIT_MAX);
        case (r_state)
            ST_IDLE: begin
                if (w_grant_any) begin
                    w_gnt       = w_grant_id ? 2'b10 : 2'b01;
                    w_shift_nxt = w_grant_id ? data1 : data0;
                    w_cnt_nxt   = '0;
                    w_hits_nxt  = '0;
                    w_last_nxt  = w_grant_id;
                    w_id_nxt    = w_grant_id;
                end
            end
            ST_SEND: begin
                w_shift_nxt = {r_shift[BYTE_W-2:0], 1'b0};
                w_cnt_nxt   = (r_cnt == SEND_LAST) ? '0 : r_cnt + CNT_W'(1);
                if (w_count_hit) begin
                    w_hits_nxt = r_hits + HIT_W'(1);
                end
            end
            ST_FLUSH: begin
                w_cnt_nxt = (r_cnt == FLUSH_LAST) ? '0 : r_cnt + CNT_W'(1);
                if (w_count_hit) begin
                    w_hits_nxt = r_hits + HIT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and registered outputs; det_in/rsp_valid/busy are precomputed
    // from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_hits      <= '0;
            r_last      <= 1'b1;
            r_id        <= 1'b0;
            r_det_in    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hits      <= w_hits_nxt;
            r_last      <= w_last_nxt;
            r_id        <= w_id_nxt;
            r_det_in    <= (w_state_nxt == ST_SEND) && w_shift_nxt[BYTE_W-1];
            r_rsp_valid <= (w_state_nxt == ST_RESP);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign gnt       = w_gnt;
    assign det_in    = r_det_in;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_hits  = r_hits;
    assign busy      = r_busy;

endmodule

// File: tb/tb_det_arb.sv
// tb_det_arb: directed bench for det_arb with a behavioural "11" detector.
module tb_det_arb;

    localparam int unsigned FLUSH_BITS = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [1:0] gnt;
    logic       det_in;
    logic       det_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [2:0] rsp_hits;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    det_arb #(.FLUSH_BITS(FLUSH_BITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .gnt       (gnt),
        .det_in    (det_in),
        .det_out   (det_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_hits  (rsp_hits),
        .busy      (busy)
    );

    // Detector: 0 -> seen one 1 -> hit (output high) -> back to 0 unconditionally.
    logic [1:0] d_st;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_st <= 2'd0;
        end else begin
            case (d_st)
                2'd0:    d_st <= det_in ? 2'd1 : 2'd0;
                2'd1:    d_st <= det_in ? 2'd2 : 2'd0;
                default: d_st <= 2'd0;
            endcase
        end
    end
    assign det_out = (d_st == 2'd2);

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One transaction starting at posedge+1 of an IDLE cycle; ends at
    // posedge+1 of the IDLE cycle following the response.
    task automatic txn(input logic [1:0] r, input logic [7:0] d0, input logic [7:0] d1,
                       input logic exp_id, input logic [7:0] byte_v, input logic [2:0] exp_hits,
                       input bit hold, input int stall);
        req       = r;
        data0     = d0;
        data1     = d1;
        rsp_ready = (stall == 0);
        @(negedge clk);
        chk("gnt", 8'(gnt), exp_id ? 8'h02 : 8'h01);
        chk("idle_busy", 8'(busy), 8'h00);
        chk("idle_det_in", 8'(det_in), 8'h00);
        @(posedge clk); #1;
        if (!hold) req = 2'b00;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("send_det_in", 8'(det_in), 8'(byte_v[7-k]));
            chk("send_gnt", 8'(gnt), 8'h00);
            chk("send_busy", 8'(busy), 8'h01);
            @(posedge clk); #1;
        end
        for (int f = 0; f < int'(FLUSH_BITS); f++) begin
            @(negedge clk);
            chk("flush_det_in", 8'(det_in), 8'h00);
            chk("flush_valid", 8'(rsp_valid), 8'h00);
            @(posedge clk); #1;
        end
        if (stall > 0) req = 2'b10;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_valid", 8'(rsp_valid), 8'h01);
            chk("stall_id", 8'(rsp_id), 8'(exp_id));
            chk("stall_hits", 8'(rsp_hits), 8'(exp_hits));
            chk("stall_det_in", 8'(det_in), 8'h00);
            chk("stall_gnt", 8'(gnt), 8'h00);
            chk("stall_busy", 8'(busy), 8'h01);
            @(posedge clk); #1;
        end
        if (stall > 0) req = 2'b00;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_valid", 8'(rsp_valid), 8'h01);
        chk("rsp_id", 8'(rsp_id), 8'(exp_id));
        chk("rsp_hits", 8'(rsp_hits), 8'(exp_hits));
        chk("rsp_gnt", 8'(gnt), 8'h00);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 2'b00;
        data0     = 8'h00;
        data1     = 8'h00;
        rsp_ready = 1'b0;
        #2;
        chk("rst_gnt", 8'(gnt), 8'h00);
        chk("rst_det_in", 8'(det_in), 8'h00);
        chk("rst_valid", 8'(rsp_valid), 8'h00);
        chk("rst_id", 8'(rsp_id), 8'h00);
        chk("rst_hits", 8'(rsp_hits), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 8'(busy), 8'h00);
        @(posedge clk); #1;

        // Basic byte from requester 0, then hit-count patterns from requester 1.
        txn(2'b01, 8'hC0, 8'h00, 1'b0, 8'hC0, 3'd1, 1'b0, 0);
        txn(2'b10, 8'h00, 8'hFF, 1'b1, 8'hFF, 3'd3, 1'b0, 0);
        txn(2'b10, 8'h00, 8'h55, 1'b1, 8'h55, 3'd0, 1'b0, 0);
        txn(2'b10, 8'h00, 8'h66, 1'b1, 8'h66, 3'd2, 1'b0, 0);

        // Both requesting continuously: strict alternation, trailing-11 byte included.
        txn(2'b11, 8'h03, 8'h36, 1'b0, 8'h03, 3'd1, 1'b1, 0);
        txn(2'b11, 8'h03, 8'h36, 1'b1, 8'h36, 3'd2, 1'b1, 0);
        txn(2'b11, 8'h03, 8'h36, 1'b0, 8'h03, 3'd1, 1'b1, 0);
        txn(2'b11, 8'h03, 8'h36, 1'b1, 8'h36, 3'd2, 1'b1, 0);
        req = 2'b00;

        // Response back-pressure for 5 cycles with a competing request pending.
        txn(2'b01, 8'hC0, 8'h00, 1'b0, 8'hC0, 3'd1, 1'b0, 5);
        txn(2'b10, 8'h00, 8'hFF, 1'b1, 8'hFF, 3'd3, 1'b0, 0);

        // Reset in SEND cycle 4 of 8'hF0 from requester 0.
        req   = 2'b01;
        data0 = 8'hF0;
        @(negedge clk);
        chk("abort_gnt", 8'(gnt), 8'h01);
        @(posedge clk); #1;
        req = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_det_in", 8'(det_in), (k < 4) ? 8'h01 : 8'h00);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("abort_pre_hits", 8'(rsp_hits), 8'h01);
        chk("abort_pre_busy", 8'(busy), 8'h01);
        rst_n = 1'b0;
        #1;
        chk("abort_gnt0", 8'(gnt), 8'h00);
        chk("abort_det_in0", 8'(det_in), 8'h00);
        chk("abort_valid0", 8'(rsp_valid), 8'h00);
        chk("abort_id0", 8'(rsp_id), 8'h00);
        chk("abort_hits0", 8'(rsp_hits), 8'h00);
        chk("abort_busy0", 8'(busy), 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_no_valid", 8'(rsp_valid), 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Pointer back at 1: both requesting grants 0; then no carry-over on requester 1.
        txn(2'b11, 8'hC0, 8'hFF, 1'b0, 8'hC0, 3'd1, 1'b0, 0);
        txn(2'b10, 8'h00, 8'h03, 1'b1, 8'h03, 3'd1, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/det_arb.md
DET_ARB -- requirements
Module: det_arb

Interface
REQ-001 Parameter: FLUSH_BITS, 2, zero bits driven after each byte to drain the detector; the block SHALL reject values below 2 at elaboration.
REQ-002 clk  input  1  single clock; all flops on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset; shared with the detector.
REQ-004 req  input  2  per-requester level request; req[i] and data_i are held stable until gnt[i].
REQ-005 data0  input  8  requester 0 byte.
REQ-006 data1  input  8  requester 1 byte.
REQ-007 gnt  output  2  one-cycle acceptance pulse, at most one bit set.
REQ-008 det_in  output  1  serial bit to the shared sequence detector (in input).
REQ-009 det_out  input  1  detector output; high while the detector is in its hit state after two consecutive 1 bits.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  result consumer ready.
REQ-012 rsp_id  output  1  requester index of the result.
REQ-013 rsp_hits  output  3  number of detector hits for the byte, 0..3.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 States: IDLE, SEND, FLUSH, RESP; 2-bit encoded; illegal encodings SHALL go to IDLE.
REQ-016 IDLE with req!=0: the block SHALL grant exactly one requester and pulse gnt in that cycle.
REQ-017 At the same edge, the block SHALL capture the granted byte into an 8-bit shift register, clear the hit counter, latch rsp_id, and go to SEND.
REQ-018 Arbitration SHALL be round-robin: a 1-bit last-grant pointer, with priority to the requester not granted last.
REQ-019 The last-grant pointer SHALL reset to 1, so that req=2'b11 out of reset grants requester 0 first.
REQ-020 SEND SHALL last exactly 8 cycles; in SEND cycle k (k=0..7), det_in SHALL equal byte bit 7-k (MSB first).
REQ-021 FLUSH SHALL last exactly FLUSH_BITS cycles with det_in=0; the detector is then in its idle state for the next byte.
REQ-022 det_in SHALL be 0 in IDLE and RESP, and SHALL be driven from registered state only (no combinational path from any input).
REQ-023 The hit counter SHALL increment in every SEND or FLUSH cycle in which det_out=1.
REQ-024 The hit counter SHALL saturate at 7; legal traffic never exceeds 3.
REQ-025 det_out SHALL be ignored in IDLE and RESP.
REQ-026 After the last FLUSH cycle, the block SHALL enter RESP.
REQ-027 In RESP, rsp_valid=1, rsp_id and rsp_hits SHALL be stable, and the block SHALL stay in RESP until rsp_ready=1.
REQ-028 On the rsp_valid&&rsp_ready cycle, the block SHALL go to IDLE; gnt SHALL not assert in RESP, so a back-to-back request waits one IDLE cycle.
REQ-029 Latency: gnt at cycle 0, first data bit at cycle 1, rsp_valid first high at cycle 9+FLUSH_BITS.
REQ-030 Changes of req during SEND, FLUSH or RESP SHALL have no effect on the block.
REQ-031 A requester that drops req before its grant SHALL simply not be granted.

Reset
REQ-032 rst_n low SHALL immediately force: state IDLE, gnt=0, det_in=0, rsp_valid=0, rsp_id=0, rsp_hits=0, busy=0, shift register 0, bit counter 0, last-grant pointer 1.
REQ-033 Reset asserted mid-SEND or mid-RESP SHALL discard the byte in flight with no response issued; after release, the block SHALL arbitrate from IDLE.
REQ-034 Reset release SHALL take effect on the first rising clk edge with rst_n high.

Verification
REQ-035 Scenario: req=01, data0=8'b1100_0000, rsp_ready=1 -> gnt=01 at cycle 0, det_in 1,1,0,0,0,0,0,0 then 0,0, rsp_valid at cycle 11 with rsp_id=0 and rsp_hits=1.
REQ-036 Scenario: data1=8'hFF via req=10 -> rsp_hits=3; data1=8'h55 -> rsp_hits=0; data1=8'b0110_0110 -> rsp_hits=2.
REQ-037 Scenario: req=11 held with 4 sequential transactions -> grants in order 0,1,0,1 with one IDLE cycle between each RESP and the next gnt.
REQ-038 Scenario: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_hits stable, det_in=0, no gnt; release -> IDLE on the next cycle.
REQ-039 Scenario: rst_n pulsed low at SEND cycle 4 of byte 8'hF0 -> all outputs 0 immediately, no rsp_valid; the next request after release yields a correct result with no carry-over.
REQ-040 Scenario: byte 8'b0000_0011 (trailing 1,1) -> the hit is counted in FLUSH cycle 0 and rsp_hits=1.
